mmio_responder: RTL and testbench

MMIO_RESPONDER -- requirements
Module: mmio_responder

---
 rtl/mmio_responder_if.sv | 24 ++
 rtl/mmio_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_mmio_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// ---------------------------------------------------------------------------
// mmio_responder_if -- CPU-side IO window bus for mmio_responder.
//
// Signals:
//   io_sel  access targets the IO window
//   io_we   store strobe (qualified by io_sel)
//   io_re   load strobe  (qualified by io_sel)
//   addr    byte offset in the window, addr[3:2] selects the register
//   wdata   store data
//   rdata   load data, combinational from the responder
//
// Modports: master (CPU side), slave (responder side).
// ---------------------------------------------------------------------------
interface mmio_responder_if;
  logic        io_sel;
  logic        io_we;
  logic        io_re;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output io_sel, io_we, io_re, addr, wdata, input rdata);
  modport slave  (input io_sel, io_we, io_re, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_responder.sv
// ---------------------------------------------------------------------------
// mmio_responder -- memory-mapped IO block: push-button/switch capture and an
// 8-digit multiplexed 7-segment hex display.
//
// Register map (addr[3:2]):
//   0x0 STATUS (RO)  bit0 = sw_ready, set by a button press, cleared by a
//                    SWDATA read
//   0x4 SWDATA (RO)  {16'h0, switches captured at the button press}
//   0x8 DISP   (RW)  eight hex nibbles, digit i shows DISP[4i+3:4i]
//   0xC reserved, reads 0, stores ignored
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   bus      mmio_responder_if.slave (io_sel/io_we/io_re/addr/wdata/rdata)
//   btn_in   raw asynchronous "input ready" push button
//   sw       raw slide switches
//   AN       digit enables, active-low
//   A2G      segments a..g on bits 6..0, active-low
//   DP       decimal point, active-low, always off
//
// Parameters:
//   DEBOUNCE_CYCLES  stable samples needed to accept a button level
//   SCAN_DIV         clk cycles each digit stays lit
//
// Build option: define MMIO_DEBOUNCE_EN to debounce the synchronized button.
// Without it the synchronized button is used directly and DEBOUNCE_CYCLES
// has no effect.
// ---------------------------------------------------------------------------
module mmio_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SCAN_DIV        = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_responder_if.slave        bus,
  input  logic                   btn_in,
  input  logic [15:0]            sw,
  output logic [7:0]             AN,
  output logic [6:0]             A2G,
  output logic                   DP
);

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_SWDATA = 2'd1,
    REG_DISP   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_e;

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  reg_e        reg_sel;
  logic        wr_disp;
  logic        rd_swdata;

  logic [31:0] disp;
  logic [15:0] swdata;
  logic        sw_ready;

  logic        btn_sync1, btn_sync2;
  logic [15:0] sw_sync1, sw_sync2;
  logic        btn_level;
  logic        btn_prev;
  logic        btn_rise;

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit_idx;

  // Byte-lane bits carry no information for word registers.
  logic addr_unused;
  assign addr_unused = ^bus.addr[1:0];

  assign reg_sel   = reg_e'(bus.addr[3:2]);
  assign wr_disp   = bus.io_sel & bus.io_we & (reg_sel == REG_DISP);
  assign rd_swdata = bus.io_sel & bus.io_re & (reg_sel == REG_SWDATA);

  // ---------------------------------------------------------------- DISP
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) disp <= '0;
    else if (wr_disp) disp <= bus.wdata;
  end

  // ------------------------------------------------------- synchronizers
  // Switches are synchronized too so the captured word is never a
  // half-settled mix of old and new positions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      sw_sync1  <= '0;
      sw_sync2  <= '0;
    end else begin
      btn_sync1 <= btn_in;
      btn_sync2 <= btn_sync1;
      sw_sync1  <= sw;
      sw_sync2  <= sw_sync1;
    end
  end

  // ------------------------------------------------------------ debounce
`ifdef MMIO_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // The count advances only while the sampled button differs from the
  // accepted level; a sample matching the old level restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (btn_sync2 != db_level) begin
      if (db_cnt == DB_LAST) begin
        db_level <= btn_sync2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign btn_level = db_level;
`else
  logic debounce_unused;
  assign debounce_unused = (DEBOUNCE_CYCLES != 0);
  assign btn_level       = btn_sync2;
`endif

  // ------------------------------------------------------------- capture
  // One capture per rising edge of the accepted level; a held button keeps
  // btn_prev high so no further captures occur until release.
  assign btn_rise = btn_level & ~btn_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev <= 1'b0;
      sw_ready <= 1'b0;
      swdata   <= '0;
    end else begin
      btn_prev <= btn_level;
      // A new press wins over a simultaneous SWDATA read.
      if (btn_rise) begin
        sw_ready <= 1'b1;
        swdata   <= sw_sync2;
      end else if (rd_swdata) begin
        sw_ready <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------- read mux
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bus.rdata = '0;
    if (bus.io_sel) begin
      case (reg_sel)
        REG_STATUS: bus.rdata = {31'h0, sw_ready};
        REG_SWDATA: bus.rdata = {16'h0, swdata};
        REG_DISP:   bus.rdata = disp;
        default:    bus.rdata = '0;
      endcase
    end
  end

  // -------------------------------------------------------- display scan
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 7'b0000001;
      4'h1: hex_seg = 7'b1001111;
      4'h2: hex_seg = 7'b0010010;
      4'h3: hex_seg = 7'b0000110;
      4'h4: hex_seg = 7'b1001100;
      4'h5: hex_seg = 7'b0100100;
      4'h6: hex_seg = 7'b0100000;
      4'h7: hex_seg = 7'b0001111;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0000100;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b1100000;
      4'hC: hex_seg = 7'b0110001;
      4'hD: hex_seg = 7'b1000010;
      4'hE: hex_seg = 7'b0110000;
      4'hF: hex_seg = 7'b0111000;
    endcase
  endfunction

  // Segments decode straight from DISP so a store shows on the lit digit
  // right after the write edge. Reset blanks the display asynchronously.
  always_comb begin
    AN  = ~(8'h01 << digit_idx);
    A2G = hex_seg(disp[{digit_idx, 2'b00} +: 4]);
    if (!reset) begin
      AN  = 8'hFF;
      A2G = 7'h7F;
    end
  end

  assign DP = 1'b1;

endmodule

// File: tb/tb_mmio_responder.sv
// ---------------------------------------------------------------------------
// tb_mmio_responder -- scoreboard bench for mmio_responder.
// Stimulus pushes expected read data and expected display states into
// queues; a negedge monitor pops and compares whenever a read strobe is
// presented or a display expectation is pending.
// Honors MMIO_DEBOUNCE_EN for the expected capture behaviour.
// ---------------------------------------------------------------------------
module tb_mmio_responder;
  localparam int DB = 8;
  localparam int SD = 4;
`ifdef MMIO_DEBOUNCE_EN
  localparam bit DB_EN   = 1'b1;
  localparam int CAP_LAT = 3 + DB;
`else
  localparam bit DB_EN   = 1'b0;
  localparam int CAP_LAT = 3;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        btn_in = 1'b0;
  logic [15:0] sw     = '0;
  logic [7:0]  AN;
  logic [6:0]  A2G;
  logic        DP;

  mmio_responder_if bus();

  mmio_responder #(.DEBOUNCE_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .btn_in (btn_in),
    .sw     (sw),
    .AN     (AN),
    .A2G    (A2G),
    .DP     (DP)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { string name; logic [31:0] data; } rd_exp_t;
  typedef struct { string name; logic [7:0] an; logic [6:0] seg; } disp_exp_t;

  rd_exp_t   rd_q[$];
  disp_exp_t disp_q[$];

  logic [31:0] disp_m = '0;   // bench copy of DISP
  int          scan_cyc;      // cycles since reset release

  always @(posedge clk or negedge reset) begin
    if (!reset) scan_cyc <= 0;
    else        scan_cyc <= scan_cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic disp_exp_t disp_expect(input string name);
    disp_exp_t d;
    int idx;
    idx    = (scan_cyc / SD) % 8;
    d.name = name;
    d.an   = ~(8'h01 << idx);
    d.seg  = glyph(disp_m[idx*4 +: 4]);
    return d;
  endfunction

  // Monitor: compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    rd_exp_t   e;
    disp_exp_t d;
    if (bus.io_re === 1'b1) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_underflow: got read with rdata %h, expected no read", bus.rdata);
      end else begin
        e = rd_q.pop_front();
        check(e.name, bus.rdata, e.data);
      end
    end
    if (disp_q.size() != 0) begin
      d = disp_q.pop_front();
      check({d.name, "_an"},  {24'h0, AN},  {24'h0, d.an});
      check({d.name, "_seg"}, {25'h0, A2G}, {25'h0, d.seg});
      check({d.name, "_dp"},  {31'h0, DP},  32'h1);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic sel = 1'b1);
    bus.io_sel = sel;
    bus.io_we  = 1'b1;
    bus.addr   = a;
    bus.wdata  = d;
    cycle();
    bus.io_sel = 1'b0;
    bus.io_we  = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [3:0] a, input logic [31:0] exp,
                         input logic sel = 1'b1);
    bus.io_sel = sel;
    bus.io_re  = 1'b1;
    bus.addr   = a;
    rd_q.push_back('{name: name, data: exp});
    cycle();
    bus.io_sel = 1'b0;
    bus.io_re  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.io_sel = 1'b0;
    bus.io_we  = 1'b0;
    bus.io_re  = 1'b0;
    bus.addr   = '0;
    bus.wdata  = '0;

    // Reset state.
    #2;
    check("rst_an",  {24'h0, AN},  32'hFF);
    check("rst_seg", {25'h0, A2G}, 32'h7F);
    check("rst_dp",  {31'h0, DP},  32'h1);
    repeat (2) @(posedge clk);
    #7 reset = 1'b1;
    #1;
    check("rel_an",  {24'h0, AN},  32'hFE);
    check("rel_seg", {25'h0, A2G}, 32'h01);
    cycle();

    // Display walk with DISP = 89ABCDEF.
    do_write(4'h8, 32'h89AB_CDEF);
    disp_m = 32'h89AB_CDEF;
    do_read("disp_rb", 4'h8, 32'h89AB_CDEF);
    for (int i = 0; i < 32; i++) begin
      disp_q.push_back(disp_expect("scan"));
      cycle();
    end

    // Mid-scan write lands on the lit digit without restarting the scan.
    do_write(4'h8, 32'h0);
    disp_m = 32'h0;
    disp_q.push_back(disp_expect("live_upd"));
    cycle();

    // Read-only / reserved stores ignored, unselected reads return 0.
    do_write(4'h0, 32'hFFFF_FFFF);
    do_write(4'h4, 32'hFFFF_FFFF);
    do_write(4'hC, 32'hFFFF_FFFF);
    do_write(4'h8, 32'hCAFE_F00D);
    disp_m = 32'hCAFE_F00D;
    do_write(4'h8, 32'h0, 1'b0);
    do_read("status_ro", 4'h0, 32'h0);
    do_read("swdata_ro", 4'h4, 32'h0);
    do_read("rsvd",      4'hC, 32'h0);
    do_read("nosel",     4'h8, 32'h0, 1'b0);
    do_read("disp_kept", 4'h8, 32'hCAFE_F00D);

    // Held button: one capture.
    sw = 16'hA5A5;
    repeat (3) cycle();
    btn_in = 1'b1;
    repeat (20) cycle();
    do_read("hold_status1", 4'h0, 32'h1);
    do_read("hold_swdata",  4'h4, 32'h0000_A5A5);
    do_read("hold_status0", 4'h0, 32'h0);
    repeat (5) cycle();
    do_read("hold_no_recap", 4'h0, 32'h0);
    btn_in = 1'b0;
    repeat (20) cycle();
    do_read("rel_status", 4'h0, 32'h0);

    // Bouncing button.
    sw = 16'h1234;
    repeat (3) cycle();
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0);
      repeat (3) cycle();
    end
    btn_in = 1'b0;
    repeat (20) cycle();
    do_read("bounce_status", 4'h0, DB_EN ? 32'h0 : 32'h1);
    do_read("bounce_swdata", 4'h4, DB_EN ? 32'h0000_A5A5 : 32'h0000_1234);
    do_read("bounce_clr",    4'h0, 32'h0);

    // Press edge coincides with a SWDATA read: set wins.
    sw = 16'h5A5A;
    repeat (3) cycle();
    btn_in = 1'b1;
    repeat (CAP_LAT - 1) cycle();
    do_read("coinc_old", 4'h4, DB_EN ? 32'h0000_A5A5 : 32'h0000_1234);
    do_read("coinc_status", 4'h0, 32'h1);
    do_read("coinc_swdata", 4'h4, 32'h0000_5A5A);
    do_read("coinc_clr",    4'h0, 32'h0);
    btn_in = 1'b0;
    repeat (DB + 5) cycle();

    // Asynchronous reset mid-scan.
    do_write(4'h8, 32'h1234_5678);
    disp_m = 32'h1234_5678;
    repeat (6) cycle();
    disp_q.push_back(disp_expect("pre_rst"));
    cycle();
    #3 reset = 1'b0;
    #1;
    check("arst_an",  {24'h0, AN},  32'hFF);
    check("arst_seg", {25'h0, A2G}, 32'h7F);
    check("arst_dp",  {31'h0, DP},  32'h1);
    disp_m = 32'h0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("rel2_an",  {24'h0, AN},  32'hFE);
    check("rel2_seg", {25'h0, A2G}, 32'h01);
    cycle();
    do_read("arst_disp",   4'h8, 32'h0);
    do_read("arst_status", 4'h0, 32'h0);
    do_read("arst_swdata", 4'h4, 32'h0);
    for (int i = 0; i < 6; i++) begin
      disp_q.push_back(disp_expect("post_rst"));
      cycle();
    end

    repeat (2) cycle();
    if (rd_q.size() != 0 || disp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d read and %0d display expectations pending, expected 0",
               rd_q.size(), disp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
